// File: rtl/code_conv_pipe.sv
// Two-stage binary<->Gray conversion pipeline with valid/ready handshake and transfer counter.
// Optional odd-parity flag on dout is compiled in with macro CODE_CONV_PARITY_EN.
module code_conv_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag,
  output logic [CNT_W-1:0] count
);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef CODE_CONV_PARITY_EN
  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             s1_mode_q,  s1_mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q,     dout_d;
  logic [CNT_W-1:0] count_q,    count_d;

  logic             in_accept_s;
  logic             s2_load_s;
  logic             out_fire_s;
  logic [WIDTH-1:0] conv_s;

  // Handshake decode; in_ready depends only on state and out_ready
  always_comb begin
    in_ready    = !s1_valid_q || !out_valid_q || out_ready;
    in_accept_s = in_valid && in_ready;
    out_fire_s  = out_valid_q && out_ready;
    s2_load_s   = s1_valid_q && (!out_valid_q || out_ready);
  end

  // Conversion uses the mode captured alongside the word in stage 1
  always_comb begin
    conv_s = {WIDTH{1'b0}};
    if (s1_mode_q) begin
      conv_s = bin2gray(s1_data_q);
    end else begin
      conv_s = gray2bin(s1_data_q);
    end
  end

  // Stage 1 next-state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (in_accept_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = din;
      s1_mode_d  = mode;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next-state; dout holds its last value once drained
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    if (s2_load_s) begin
      out_valid_d = 1'b1;
      dout_d      = conv_s;
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Completed-transfer counter, wraps naturally
  always_comb begin
    count_d = count_q;
    if (out_fire_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline registers; reset discards in-flight words
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {WIDTH{1'b0}};
      s1_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= {WIDTH{1'b0}};
      count_q     <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      count_q     <= count_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

`ifdef CODE_CONV_PARITY_EN
  logic flag_q, flag_d;

  // Parity is registered together with dout so the two always match
  always_comb begin
    flag_d = flag_q;
    if (s2_load_s) begin
      flag_d = odd_parity(conv_s);
    end else begin
      flag_d = flag_q;
    end
  end

  // Parity flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;
`else
  assign flag = 1'b0;
`endif

endmodule

// File: doc/code_conv_pipe.md
CODE_CONV_PIPE -- requirements
Module: code_conv_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, data word width in bits (>=2).
REQ-002 SHALL provide parameter CNT_W, default 8, width of the completed-transfer counter.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL provide port mode  input  1  per-word conversion select: 1 = binary-to-Gray, 0 = Gray-to-binary.
REQ-006 SHALL provide port din  input  WIDTH  input word.
REQ-007 SHALL provide port in_valid  input  1  din/mode valid this cycle.
REQ-008 SHALL provide port in_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL provide port dout  output  WIDTH  converted word.
REQ-010 SHALL provide port out_valid  output  1  dout/flag valid.
REQ-011 SHALL provide port out_ready  input  1  downstream accepts dout this cycle.
REQ-012 SHALL provide port flag  output  1  odd-parity indicator of dout (see Configuration).
REQ-013 SHALL provide port count  output  CNT_W  number of completed output transfers.

Function
REQ-014 SHALL implement a two-stage pipeline: stage 1 registers din and mode; stage 2 registers the converted word and flag.
REQ-015 SHALL accept a word on an edge where in_valid=1 and in_ready=1; transfer on output on an edge where out_valid=1 and out_ready=1.
REQ-016 SHALL compute in_ready combinationally as (!s1_valid) or (!s2_valid) or out_ready; no combinational path from in_valid to in_ready.
REQ-017 SHALL, with out_ready held 1, present the result with out_valid=1 after the second rising edge following acceptance (latency 2 cycles, throughput 1 word/cycle).
REQ-018 SHALL compute binary-to-Gray as g[i]=b[i]^b[i+1], g[WIDTH-1]=b[WIDTH-1].
REQ-019 SHALL compute Gray-to-binary as b[WIDTH-1]=g[WIDTH-1], b[i]=b[i+1]^g[i], fully in stage 2 logic.
REQ-020 SHALL use the mode captured with each word, so mode changes between words never affect in-flight data.
REQ-021 SHALL hold dout, flag and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve word order; no word dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 SHALL, with both stages full and out_ready=0, deassert in_ready; with out_ready=1 on the same edge, accept a new word while shifting (simultaneous in/out).
REQ-024 SHALL increment count by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-025 SHALL keep dout at its last value when out_valid=0 (no X, no clearing except by reset).

Reset
REQ-026 SHALL, on rst=1 at a rising edge, clear s1_valid, out_valid, dout, flag and count to 0; in_ready=1 in the following cycle.
REQ-027 SHALL discard in-flight words on reset mid-operation; no transfer occurs on the reset edge.
REQ-028 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 SHALL compile the parity output under macro CODE_CONV_PARITY_EN.
REQ-030 SHALL, with CODE_CONV_PARITY_EN defined, drive flag as XOR-reduction of the registered dout (1 = odd number of ones), registered with dout.
REQ-031 SHALL, without CODE_CONV_PARITY_EN, tie flag to 0 and instantiate no parity logic.

Verification (WIDTH=4, CNT_W=4)
REQ-032 SHALL check mode=1, din=1011, out_ready=1 -> two cycles later dout=1110, flag=1 (0 without macro), count=1.
REQ-033 SHALL check mode=0, din=1110 -> dout=1011, flag=1; back-to-back words 0000,0001,0010 with mode=1 -> 0000,0001,0011 on consecutive cycles.
REQ-034 SHALL check out_ready=0, three words offered -> two held, in_ready=0, dout stable; out_ready=1 -> all three emerge in order, count=3.
REQ-035 SHALL check 16 consecutive transfers -> count wraps to 0.
REQ-036 SHALL check rst=1 with both stages full -> next cycle out_valid=0, dout=0000, count=0, in_ready=1; no stale word later emerges.
REQ-037 SHALL check mode toggling every cycle with din=0110 -> outputs alternate 0101 (B2G) and 0100 (G2B).
